// File: rtl/i2c_fifo_bridge.sv
// Host-to-I2C byte bridge: paced TX FIFO feeding a start/busy/done byte core, read-back bytes into an RX FIFO.
// Optional transaction timeout enabled by defining I2C_BRIDGE_TIMEOUT_EN.
module i2c_fifo_bridge #(
    parameter int DATA_W      = 8,
    parameter int TX_AW       = 4,
    parameter int RX_AW       = 4,
    parameter int PACE_DIV    = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk50mhz,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] core_data,
    output logic              core_start,
    input  logic              core_busy,
    input  logic              core_wdone,
    input  logic              core_rdone,
    input  logic [DATA_W-1:0] core_rddata,
    output logic [TX_AW:0]    tx_level,
    output logic [RX_AW:0]    rx_level,
    output logic              rx_ovf,
    output logic              err_timeout,
    input  logic              clr_err
);

    localparam int TX_D   = 1 << TX_AW;
    localparam int RX_D   = 1 << RX_AW;
    localparam int PACE_W = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(PACE_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] tx_mem [TX_D];
    logic [DATA_W-1:0] rx_mem [RX_D];
    logic [TX_AW:0]    tx_wptr, tx_rptr;
    logic [RX_AW:0]    rx_wptr, rx_rptr;
    logic [PACE_W-1:0] pace;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic issue, ovf_set, tmo_set;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                      (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);
    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                      (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);

    assign s_ready    = !tx_full;
    assign m_valid    = !rx_empty;
    assign m_data     = rx_mem[rx_rptr[RX_AW-1:0]];
    assign tx_level   = tx_wptr - tx_rptr;
    assign rx_level   = rx_wptr - rx_rptr;
    assign core_start = (state == START);

    assign tx_push = s_valid && s_ready;
    assign tx_pop  = issue;
    assign rx_pop  = m_valid && m_ready;

`ifdef I2C_BRIDGE_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        err_timeout_r;
    assign err_timeout = err_timeout_r;
`else
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        rx_push    = 1'b0;
        ovf_set    = 1'b0;
        tmo_set    = 1'b0;
        case (state)
            IDLE: begin
                if (pace == PACE_LAST && !tx_empty && !core_busy) begin
                    issue      = 1'b1;
                    state_next = START;
                end
            end
            START: state_next = WAIT;
            WAIT: begin
                // a simultaneous wdone+rdone counts as one completion carrying read data
                if (core_wdone || core_rdone) begin
                    state_next = IDLE;
                    if (core_rdone) begin
                        if (!rx_full || rx_pop) rx_push = 1'b1;
                        else                    ovf_set = 1'b1;
                    end
                end
`ifdef I2C_BRIDGE_TIMEOUT_EN
                else if (wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
                    tmo_set    = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            state     <= IDLE;
            pace      <= '0;
            tx_wptr   <= '0;
            tx_rptr   <= '0;
            rx_wptr   <= '0;
            rx_rptr   <= '0;
            core_data <= '0;
            rx_ovf    <= 1'b0;
        end else begin
            state <= state_next;
            pace  <= (pace == PACE_LAST) ? '0 : pace + 1'b1;
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            if (issue)   core_data <= tx_mem[tx_rptr[TX_AW-1:0]];
            if (ovf_set)      rx_ovf <= 1'b1;
            else if (clr_err) rx_ovf <= 1'b0;
        end
    end

`ifdef I2C_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            wait_cnt      <= '0;
            err_timeout_r <= 1'b0;
        end else begin
            if (state == START)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (tmo_set)      err_timeout_r <= 1'b1;
            else if (clr_err) err_timeout_r <= 1'b0;
        end
    end
`endif

    // storage arrays carry no reset; occupancy is governed by the pointers alone
    always_ff @(posedge clk50mhz) begin
        if (tx_push) tx_mem[tx_wptr[TX_AW-1:0]] <= s_data;
        if (rx_push) rx_mem[rx_wptr[RX_AW-1:0]] <= core_rddata;
    end

endmodule

// File: tb/tb_i2c_fifo_bridge.sv
// Self-checking bench for i2c_fifo_bridge: vector table of transactions plus TX/RX scoreboard queues.
module tb_i2c_fifo_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] core_data;
    logic       core_start;
    logic       core_busy = 1'b0;
    logic       core_wdone = 1'b0;
    logic       core_rdone = 1'b0;
    logic [7:0] core_rddata = '0;
    logic [4:0] tx_level;
    logic [4:0] rx_level;
    logic       rx_ovf;
    logic       err_timeout;
    logic       clr_err = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    typedef struct {
        logic [7:0] wdata;
        bit         rd;
        logic [7:0] rdd;
        int         dly;
        int         exp_rx;
    } vec_t;
    vec_t vecs[6];

    always #10 clk = ~clk;

    i2c_fifo_bridge #(
        .DATA_W(8), .TX_AW(4), .RX_AW(4), .PACE_DIV(4), .TIMEOUT_CYC(20)
    ) dut (
        .clk50mhz(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .core_data(core_data), .core_start(core_start), .core_busy(core_busy),
        .core_wdone(core_wdone), .core_rdone(core_rdone), .core_rddata(core_rddata),
        .tx_level(tx_level), .rx_level(rx_level),
        .rx_ovf(rx_ovf), .err_timeout(err_timeout), .clr_err(clr_err)
    );

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // issued bytes must match the written order and land on a pace slot
    always @(negedge clk) begin
        if (!rst && core_start === 1'b1) begin
            start_cnt++;
            check("issue_pace_slot", cyc % 4, 0);
            if (tx_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL issue_unexpected: core_data=%0h with nothing queued", core_data);
            end else begin
                check("issue_data", core_data, tx_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (rx_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx_unexpected: m_data=%0h with nothing expected", m_data);
            end else begin
                check("rx_data", m_data, rx_q.pop_front());
            end
        end
    end

    task automatic wr(input logic [7:0] d);
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = d;
        #1;
        if (s_ready) tx_q.push_back(d);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int  n = 0;
        bit  found = 0;
        while (n < 60 && !found) begin
            @(negedge clk);
            if (core_start === 1'b1) found = 1;
            n++;
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL %s: core_start not seen within 60 cycles", name);
        end
    endtask

    task automatic pulse(input bit wd, input bit rd, input logic [7:0] rdd, input bit mr);
        @(posedge clk); #1;
        core_wdone  = wd;
        core_rdone  = rd;
        core_rddata = rdd;
        m_ready     = mr;
        @(posedge clk); #1;
        core_wdone = 1'b0;
        core_rdone = 1'b0;
        m_ready    = 1'b0;
    endtask

    task automatic drain(input int n);
        @(posedge clk); #1;
        m_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    initial begin
        int s0;
        vecs[0] = '{8'hA5, 1'b0, 8'h00, 0, 0};
        vecs[1] = '{8'h5A, 1'b1, 8'h11, 2, 1};
        vecs[2] = '{8'hFF, 1'b0, 8'h00, 5, 1};
        vecs[3] = '{8'h00, 1'b1, 8'h22, 0, 2};
        vecs[4] = '{8'h80, 1'b1, 8'h33, 7, 3};
        vecs[5] = '{8'h7E, 1'b0, 8'h00, 1, 3};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_data", core_data, 0);
        check("rst_rx_ovf", rx_ovf, 0);
        check("rst_err_timeout", err_timeout, 0);

        // single transactions, writes and reads mixed, RX left undrained
        for (int i = 0; i < 6; i++) begin
            wr(vecs[i].wdata);
            check("vec_tx_level_after_write", tx_level, 1);
            wait_start("vec_issue");
            check("vec_tx_level_after_issue", tx_level, 0);
            @(negedge clk);
            check("vec_start_one_cycle", core_start, 0);
            repeat (vecs[i].dly) @(posedge clk);
            if (vecs[i].rd) rx_q.push_back(vecs[i].rdd);
            pulse(!vecs[i].rd, vecs[i].rd, vecs[i].rdd, 1'b0);
            check("vec_rx_level", rx_level, vecs[i].exp_rx);
        end
        drain(3);
        check("vec_rx_drained", rx_level, 0);
        check("vec_m_valid_low", m_valid, 0);

        // fill TX while the core is busy
        core_busy = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'(i));
        check("txfull_level", tx_level, 16);
        check("txfull_s_ready", s_ready, 0);
        wr(8'hEE);
        check("txfull_no_write", tx_level, 16);
        repeat (8) @(posedge clk);
        #1;
        check("busy_holds_issue", tx_level, 16);
        core_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_start("burst_issue");
            pulse(1'b1, 1'b0, 8'h00, 1'b0);
        end
        check("burst_tx_empty", tx_level, 0);

        // 17 reads into a 16-deep RX, last one overflows
        for (int i = 0; i < 17; i++) begin
            wr(8'h40 + 8'(i));
            wait_start("rx_fill_issue");
            if (i < 16) rx_q.push_back(8'h3C + 8'(i));
            pulse(1'b0, 1'b1, 8'h3C + 8'(i), 1'b0);
            if (i == 15) begin
                check("rx16_level", rx_level, 16);
                check("rx16_no_ovf", rx_ovf, 0);
            end
        end
        check("rx17_level", rx_level, 16);
        check("rx17_ovf", rx_ovf, 1);
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        check("clr_err_ovf", rx_ovf, 0);

        // full RX with push and pop in the same cycle
        wr(8'h55);
        wait_start("rx_full_pop_issue");
        rx_q.push_back(8'hC7);
        pulse(1'b0, 1'b1, 8'hC7, 1'b1);
        check("rx_pushpop_level", rx_level, 16);
        check("rx_pushpop_no_ovf", rx_ovf, 0);
        drain(16);
        check("rx_drain_level", rx_level, 0);
        check("rx_drain_m_valid", m_valid, 0);

        // no done ever arrives
        wr(8'hC3);
        wait_start("stall_issue");
        @(posedge clk);
        s0 = start_cnt;
        wr(8'hC4);
        repeat (40) @(posedge clk);
        #1;
`ifdef I2C_BRIDGE_TIMEOUT_EN
        check("tmo_err_set", err_timeout, 1);
        check("tmo_next_issue", start_cnt > s0, 1);
`else
        check("stall_no_err", err_timeout, 0);
        check("stall_no_issue", start_cnt, s0);
        check("stall_tx_level", tx_level, 1);
`endif

        // reset while waiting, then a late done pulse
        @(posedge clk); #1;
        rst = 1'b1;
        tx_q.delete();
        rx_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_tx_level", tx_level, 0);
        check("midrst_core_start", core_start, 0);
        check("midrst_err_timeout", err_timeout, 0);
        s0 = start_cnt;
        pulse(1'b1, 1'b1, 8'h99, 1'b0);
        check("midrst_rx_level", rx_level, 0);
        check("midrst_m_valid", m_valid, 0);
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_issue", start_cnt, s0);
        check("final_txq_empty", tx_q.size(), 0);
        check("final_rxq_empty", rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_fifo_bridge.md
# i2c_fifo_bridge

Parametrised single-clock successor to the team's I2C transmit FIFO wrapper. Buffers outgoing bytes in a TX FIFO, paces issue to an external I2C byte core (start/busy/done handshake), and captures read-back bytes into an RX FIFO with a ready/valid output. Adds configurable depths, configurable pacing, RX buffering, sticky error flags and an optional transaction timeout. Sits between the UART/host byte stream and the I2C master core on clk50mhz.

## Interface
- DATA_W, 8, byte width on all data ports
- TX_AW, 4, TX FIFO address bits (depth 2^TX_AW)
- RX_AW, 4, RX FIFO address bits (depth 2^RX_AW)
- PACE_DIV, 4, issue slot every PACE_DIV cycles (≥1)
- TIMEOUT_CYC, 65535, max cycles waiting for core done (timeout build only)

- clk50mhz  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_data  in  DATA_W  TX byte
- s_valid  in  1  TX byte valid
- s_ready  out  1  = !tx_full
- m_data  out  DATA_W  RX FIFO head
- m_valid  out  1  = !rx_empty
- m_ready  in  1  RX pop request
- core_data  out  DATA_W  byte to I2C core, stable from issue until return to IDLE
- core_start  out  1  one-cycle issue pulse
- core_busy  in  1  core busy
- core_wdone  in  1  core write-done pulse
- core_rdone  in  1  core read-done pulse, core_rddata valid same cycle
- core_rddata  in  DATA_W  read-back byte
- tx_level  out  TX_AW+1  TX occupancy
- rx_level  out  RX_AW+1  RX occupancy
- rx_ovf  out  1  sticky: read byte dropped, RX full
- err_timeout  out  1  sticky: done never arrived
- clr_err  in  1  clears sticky flags

## Operation
- FIFOs: show-ahead, head combinational from array; pointers AW+1 bits, full = MSB differ & rest equal.
- TX write on s_valid&&s_ready. Write and sequencer pop same cycle: both occur, level unchanged.
- Pace counter free-runs 0..PACE_DIV-1, wraps; PACE_DIV=1 → every cycle is a slot.
- FSM states: IDLE, START, WAIT.
- IDLE → START when pace==PACE_DIV-1 && !tx_empty && !core_busy: core_data<=head, TX pop, core_start<=1.
- START (1 cycle, core_start=1) → WAIT; core_start<=0.
- WAIT → IDLE on core_wdone|core_rdone. If core_rdone: push core_rddata to RX; if RX full and no same-cycle pop → drop byte, set rx_ovf. wdone+rdone together: one push, one transition.
- Done pulses in IDLE/START ignored.
- RX pop on m_valid&&m_ready. Full RX with simultaneous pop and push: push accepted, no ovf.
- No bypass: byte written into empty TX is seen by FSM next cycle.
- clr_err clears rx_ovf/err_timeout; set event same cycle wins.

## Timing
- Reset values: s_ready=1, m_valid=0, m_data=array content (don't care), core_data=0, core_start=0, tx_level=0, rx_level=0, rx_ovf=0, err_timeout=0, pace=0, state=IDLE.
- Reset mid-transaction: next cycle IDLE, core_start=0, both FIFOs empty; popped byte lost.
- Issue latency: qualifying IDLE cycle N → core_start high in N+1 only.
- Min byte-to-byte spacing: max(PACE_DIV, 3 + done latency) cycles, next issue aligned to pace slot.
- rx_level/m_valid update cycle after rdone edge; tx_level updates cycle after write/pop.

## Configuration
- I2C_BRIDGE_TIMEOUT_EN defined: 16-bit wait counter cleared on entering WAIT; after TIMEOUT_CYC WAIT cycles without done → set err_timeout, → IDLE, byte discarded.
- Undefined: WAIT held indefinitely; err_timeout tied 0, no counter logic.

## Test plan
- Reset, write 0xA5 with PACE_DIV=4, core_busy=0 → core_start one cycle at next slot, core_data=0xA5, tx_level 1→0.
- Write 16 bytes while core_busy=1 → s_ready=0 at tx_level=16; release busy → bytes issued in order 0x00..0x0F, one per done.
- core_rdone with core_rddata=0x3C, m_ready=0 ×17 → rx_level=16, rx_ovf=1 on 17th; clr_err → rx_ovf=0; m_ready=1 drains 16 bytes FIFO order.
- Full RX, rdone and m_ready same cycle → rx_level stays 16, rx_ovf=0.
- Timeout build, TIMEOUT_CYC=20, no done → err_timeout=1 after 20 WAIT cycles, FSM issues next queued byte; non-timeout build stays in WAIT.
- Assert rst during WAIT then pulse core_wdone → no RX push, levels 0, core_start=0.
